wdog_ms: RTL and testbench

- Millisecond watchdog, directly downstream of the millisecond timer; consumes its `ms_tick` strobe (one clock wide, once per ms).
- Software arms it with a timeout in ms and must kick it periodically through an IO register.
- If the countdown reaches zero, the block asserts a stretched `trig` pulse; the system reset/restart logic consumes that pulse.

---
 rtl/wdog_ms.sv | 158 +++++++++++++++
 tb/tb_wdog_ms.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wdog_ms.sv
// -----------------------------------------------------------------------------
// wdog_ms - millisecond watchdog
//
// Software arms the watchdog by loading a timeout in milliseconds and must then
// kick it periodically. Each ms_tick strobe from the millisecond timer
// decrements the countdown. When the countdown expires, trig is raised for
// trig_cycles clk cycles so that the system reset/restart logic can act on it.
//
// A write (stb & we) carries a command in data_in[16]:
//   0 = load : timeout and counter <- data_in[timeout_width-1:0]; this also
//              clears expired/trig. A zero value disables the watchdog.
//   1 = kick : counter <- timeout, but only while RUNNING.
// If a write and ms_tick arrive in the same cycle, the write wins.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   ms_tick   in   1-cycle strobe, once per millisecond (synchronous to clk)
//   stb       in   IO register select
//   we        in   write enable, qualified by stb
//   data_in   in   [31:0] write data
//   data_out  out  [31:0] status: {13'b0, trig, expired, running, counter[15:0]}
//   trig      out  watchdog expiry pulse, trig_cycles clk cycles wide
// -----------------------------------------------------------------------------
module wdog_ms #(
    parameter int timeout_width = 16,   // legal range 1..16
    parameter int trig_cycles   = 4     // legal range 1..255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ms_tick,
    input  logic        stb,
    input  logic        we,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        trig
);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_EXPIRED  = 2'd2
    } state_t;

    localparam logic [timeout_width-1:0] CNT_ONE = timeout_width'(1);
    // The expiry edge itself is the first trig cycle, so the stretch counter
    // starts at trig_cycles-1 and trig drops on the edge after it reaches 0.
    localparam logic [7:0] STRETCH_INIT = 8'(trig_cycles - 1);

    state_t                     r_state;
    logic [timeout_width-1:0]   r_timeout;
    logic [timeout_width-1:0]   r_counter;
    logic                       r_expired;
    logic                       r_trig;
    logic [7:0]                 r_stretch;

    state_t                     w_state_nxt;
    logic [timeout_width-1:0]   w_timeout_nxt;
    logic [timeout_width-1:0]   w_counter_nxt;
    logic                       w_expired_nxt;
    logic                       w_trig_nxt;
    logic [7:0]                 w_stretch_nxt;

    logic                       w_write;
    logic                       w_load;
    logic                       w_kick;
    logic [timeout_width-1:0]   w_load_val;
    logic [15:0]                w_counter_ext;
    logic                       w_unused;

    assign w_write    = stb & we;
    assign w_load     = w_write & ~data_in[16];
    assign w_kick     = w_write &  data_in[16];
    assign w_load_val = data_in[timeout_width-1:0];

    // Only the low timeout bits and the command bit are decoded; the rest of
    // the write word is deliberately ignored.
    assign w_unused = ^data_in;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: non-blocking assignments in clocked logic, so every register
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_DISABLED;
            r_timeout <= '0;
            r_counter <= '0;
            r_expired <= 1'b0;
            r_trig    <= 1'b0;
            r_stretch <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_timeout <= w_timeout_nxt;
            r_counter <= w_counter_nxt;
            r_expired <= w_expired_nxt;
            r_trig    <= w_trig_nxt;
            r_stretch <= w_stretch_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a hold value first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_timeout_nxt = r_timeout;
        w_counter_nxt = r_counter;
        w_expired_nxt = r_expired;
        w_trig_nxt    = r_trig;
        w_stretch_nxt = r_stretch;

        // The trig stretch runs on its own; kicks and ticks do not disturb it.
        if (r_trig) begin
            if (r_stretch == '0) begin
                w_trig_nxt = 1'b0;
            end else begin
                w_stretch_nxt = r_stretch - 8'd1;
            end
        end

        if (w_load) begin
            w_timeout_nxt = w_load_val;
            w_counter_nxt = w_load_val;
            w_expired_nxt = 1'b0;
            w_trig_nxt    = 1'b0;
            w_stretch_nxt = '0;
            w_state_nxt   = (w_load_val != '0) ? ST_RUNNING : ST_DISABLED;
        end else if (w_kick) begin
            if (r_state == ST_RUNNING) begin
                w_counter_nxt = r_timeout;
            end
        end else if (ms_tick && (r_state == ST_RUNNING)) begin
            if (r_counter == CNT_ONE) begin
                w_counter_nxt = '0;
                w_state_nxt   = ST_EXPIRED;
                w_expired_nxt = 1'b1;
                w_trig_nxt    = 1'b1;
                w_stretch_nxt = STRETCH_INIT;
            end else if (r_counter != '0) begin
                // RUNNING never holds 0, but the guard keeps the counter from
                // wrapping under any circumstance.
                w_counter_nxt = r_counter - CNT_ONE;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Status readback
    // -------------------------------------------------------------------------
    assign w_counter_ext = 16'(r_counter);
    assign data_out      = {13'd0, r_trig, r_expired, (r_state == ST_RUNNING), w_counter_ext};
    assign trig          = r_trig;

endmodule

// File: tb/tb_wdog_ms.sv
// -----------------------------------------------------------------------------
// tb_wdog_ms - self-checking bench for wdog_ms
//
// A behavioural model tracks the watchdog as plain numbers: whether it is
// running, the remaining milliseconds, and the clock cycle on which it last
// fired. trig is derived from "cycles elapsed since firing". A compare process
// checks data_out and trig against the model on every falling clk edge.
// Directed sequences with literal expectations pin both DUT and model, then a
// randomized phase exercises writes, ticks and asynchronous resets.
// -----------------------------------------------------------------------------
module tb_wdog_ms;

    localparam int TW   = 16;
    localparam int TRIG = 4;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic        ms_tick = 1'b0;
    logic        stb     = 1'b0;
    logic        we      = 1'b0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        trig;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    wdog_ms #(
        .timeout_width (TW),
        .trig_cycles   (TRIG)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ms_tick  (ms_tick),
        .stb      (stb),
        .we       (we),
        .data_in  (data_in),
        .data_out (data_out),
        .trig     (trig)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------------
    int unsigned m_timeout = 0;
    int unsigned m_counter = 0;
    bit          m_running = 1'b0;
    bit          m_expired = 1'b0;
    bit          m_fired   = 1'b0;
    longint      m_cyc     = 0;
    longint      m_fire_cyc = 0;

    function automatic int unsigned low_bits(input logic [31:0] d);
        return d & ((32'd1 << TW) - 32'd1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_timeout <= 0;
            m_counter <= 0;
            m_running <= 1'b0;
            m_expired <= 1'b0;
            m_fired   <= 1'b0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (stb && we && !data_in[16]) begin
                m_timeout <= low_bits(data_in);
                m_counter <= low_bits(data_in);
                m_running <= (low_bits(data_in) != 0);
                m_expired <= 1'b0;
                m_fired   <= 1'b0;
            end else if (stb && we) begin
                if (m_running) m_counter <= m_timeout;
            end else if (ms_tick && m_running) begin
                if (m_counter == 1) begin
                    m_counter  <= 0;
                    m_running  <= 1'b0;
                    m_expired  <= 1'b1;
                    m_fired    <= 1'b1;
                    m_fire_cyc <= m_cyc + 1;
                end else begin
                    m_counter <= m_counter - 1;
                end
            end
        end
    end

    // trig is high on the firing edge and the TRIG-1 edges after it.
    function automatic logic model_trig();
        return m_fired && ((m_cyc - m_fire_cyc) < TRIG);
    endfunction

    function automatic logic [31:0] model_out();
        return {13'd0, model_trig(), m_expired, m_running, 16'(m_counter)};
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_data_out", data_out, model_out());
            check("cmp_trig", {31'd0, trig}, {31'd0, model_trig()});
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    // One bus cycle: drive on the falling edge, let the rising edge take it,
    // then return inputs to idle just after the edge.
    task automatic op(input logic s, input logic w, input logic [31:0] d, input logic t);
        @(negedge clk);
        stb = s; we = w; data_in = d; ms_tick = t;
        @(posedge clk);
        #1;
        stb = 1'b0; we = 1'b0; data_in = '0; ms_tick = 1'b0;
    endtask

    task automatic load(input logic [31:0] d);
        op(1'b1, 1'b1, d, 1'b0);
    endtask

    task automatic tick();
        op(1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #20 rst_n = 1'b1;
        cmp_en = 1'b1;
        check("reset_value", data_out, 32'h0);

        // ---- Basic expiry: load 3, three ticks ----
        load(32'h3);
        check("load3", data_out, 32'h0001_0003);
        tick();
        check("exp_tick1", data_out, 32'h0001_0002);
        tick();
        check("exp_tick2", data_out, 32'h0001_0001);
        tick();
        check("exp_tick3", data_out, 32'h0006_0000);
        for (int k = 1; k <= TRIG; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("trig_width_%0d", k), {31'd0, trig}, (k < TRIG) ? 32'd1 : 32'd0);
        end
        check("expired_idle", data_out, 32'h0002_0000);
        tick();
        tick();
        check("expired_hold", data_out, 32'h0002_0000);

        // ---- Kick ----
        load(32'h5);
        tick(); tick(); tick();
        check("kick_pre", data_out, 32'h0001_0002);
        load(32'h0001_0000);
        check("kick_reload", data_out, 32'h0001_0005);
        tick(); tick(); tick(); tick();
        check("kick_4ticks", data_out, 32'h0001_0001);
        tick();
        check("kick_expire", data_out, 32'h0006_0000);

        // ---- Kick coincident with the expiring tick ----
        load(32'h2);
        tick();
        op(1'b1, 1'b1, 32'h0001_0000, 1'b1);
        check("kick_vs_tick", data_out, 32'h0001_0002);

        // ---- Load 0 coincident with a tick ----
        op(1'b1, 1'b1, 32'h0, 1'b1);
        check("load0_vs_tick", data_out, 32'h0);
        tick();
        check("disabled_tick", data_out, 32'h0);

        // ---- Recovery while trig is high ----
        load(32'h1);
        tick();
        check("rec_expire", data_out, 32'h0006_0000);
        load(32'h0001_0000);
        check("rec_kick_ignored", data_out, 32'h0006_0000);
        load(32'hA);
        check("rec_load10", data_out, 32'h0001_000A);

        // ---- Upper bits / command bit ----
        load(32'h0);
        load(32'hFFFF_0007);
        check("kick_in_disabled", data_out, 32'h0);
        load(32'hFFFE_0007);
        check("load_upper_ignored", data_out, 32'h0001_0007);
        op(1'b1, 1'b0, 32'h0000_0003, 1'b0);
        check("stb_no_we", data_out, 32'h0001_0007);

        // ---- Asynchronous reset mid-countdown ----
        load(32'h5);
        check("rst_pre", data_out, 32'h0001_0005);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_data", data_out, 32'h0);
        check("rst_async_trig", {31'd0, trig}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick();
        check("rst_no_count", data_out, 32'h0);

        // ---- Randomized phase ----
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            stb     = ($urandom_range(0, 7) == 0);
            we      = ($urandom_range(0, 3) != 0);
            ms_tick = ($urandom_range(0, 2) == 0);
            data_in = $urandom;
            data_in[15:0] = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'($urandom_range(0, 6));
            if ($urandom_range(0, 599) == 0) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        stb = 1'b0; we = 1'b0; ms_tick = 1'b0; data_in = '0;
        do_reset();
        @(negedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
